order_encoder2_2: RTL and testbench
===================================

# order_encoder2_2

Order-function encoder and serialiser for the control section. It is the transmit-side counterpart of the order decoder. It accepts a one-hot operation selection (blank, D, F, H, M, N, φ, θ) and encodes it into function digits f13–f15, which it presents two ways:
- in parallel, on dual-rail lines;
- serially, one dual-rail digit per digit pulse, least-significant digit first, for writing into the order stream.

## Interface

Parameters: none; the function field width is fixed at 3 digits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load  in  1  request to capture the op_* inputs and start serialisation
- op_blank, op_d, op_f, op_h, op_m, op_n, op_phi, op_theta  in  1 each  one-hot operation select, sampled only when load=1
- digit_pulse  in  1  digit-time strobe; one serial digit is emitted per strobe
- busy  out  1  capture done, serialisation in progress
- done  out  1  one-cycle pulse coincident with the last serial digit
- err  out  1  one-cycle pulse: load rejected because the op_* inputs were not one-hot
- f13_pos, f13_neg, f14_pos, f14_neg, f15_pos, f15_neg  out  1 each  parallel dual-rail function digits
- ser_pos, ser_neg  out  1 each  serial dual-rail digit

## Operation

- Encoding, with code = {f15,f14,f13}: blank=000, d=001, f=010, h=011, m=100, n=101, phi=110, theta=111.
- Dual-rail convention:
  - digit 1 → pos=1, neg=0;
  - digit 0 → pos=0, neg=1;
  - null/spacer → both 0.
  - Both-1 is never driven.
- State machine: IDLE, SHIFT.
- IDLE:
  - load=1 with exactly one op_* high: latch the 3-bit code, drive the parallel lines from it, clear the digit counter to 0, go to SHIFT.
  - load=1 with zero or more than one op_* high: pulse err and stay in IDLE. The latched code and parallel lines are unchanged.
  - load=0: no action.
- SHIFT:
  - On each cycle with digit_pulse=1, emit digit[count] (count 0→f13, 1→f14, 2→f15) on ser_pos/ser_neg in the following cycle, then increment count.
  - When the emitted digit is count=2, also pulse done and return to IDLE.
  - Cycles without digit_pulse leave ser_pos/ser_neg at null and the count unchanged.
- load while in SHIFT is ignored: no capture and no err.
- Parallel lines hold the latched code from capture until the next successful capture or reset. They do not return to null between orders.
- Counter is 2 bits wide; only 0..2 are reachable. No wrap occurs, because the transition to IDLE happens on count=2.

## Timing

- Reset (synchronous, with rst high at a clk edge):
  - state=IDLE, count=0, latched code=000;
  - busy=0, done=0, err=0, ser_pos=ser_neg=0;
  - all f1x_pos/f1x_neg=0 (null).
- rst has priority over all other inputs. Asserting rst mid-SHIFT aborts the order: the next cycle shows the reset values, and done does not pulse.
- Capture: load at cycle t → at t+1, busy=1 and parallel lines are valid. Rejection: err=1 at t+1 only.
- A digit_pulse coincident with load at cycle t is not counted. The first counted pulse is at t+1 or later.
- Digit pulse at cycle k in SHIFT → ser_pos/ser_neg valid for exactly cycle k+1; they are null otherwise.
- Third digit pulse at cycle k → at k+1: ser valid (f15), done=1, busy=0, state=IDLE. A load at k+1 is accepted, so back-to-back orders are possible.
- Latency from load to done with digit pulses on every cycle from t+1: done at t+4.
- busy is registered and equals (state==SHIFT).

## Test plan

- Reset: assert rst for 2 cycles while driving load=1, op_theta=1 → all outputs 0; no capture.
- Encode sweep: for each op in turn, load then 3 digit pulses → parallel lines match the table (e.g. op_h → f13_pos=1, f14_pos=1, f15_neg=1); serial sequence for h is pos, pos, neg. For theta, 3 pos digits. For blank, 3 neg digits and parallel f1x_neg=1.
- Sparse pulses: op_m, with digit_pulse at cycles +3, +7, +8 after capture → ser digits neg at +4, neg at +8, pos at +9; done at +9; ser is null in all other cycles.
- Invalid load: op_d and op_f both 1 with load → err=1 for one cycle, busy stays 0, parallel lines keep the previous code. All-zero op_* with load → err. load during SHIFT → ignored; the serial stream completes with the original code.
- Back-to-back: op_n, then load op_phi in the done cycle → phi is captured. Parallel lines change to 110 in the cycle after done; serial digits are neg, pos, pos.
- Reset mid-order: rst after the first serial digit → null outputs; no done pulse. A subsequent op_f load serialises normally: neg, pos, neg.

Source files
------------

// File: rtl/order_encoder2_2.sv
// Order-function encoder: one-hot op select to dual-rail digits f13..f15,
// presented in parallel and serially (f13 first), one digit per digit pulse.
module order_encoder2_2 (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic op_blank,
    input  logic op_d,
    input  logic op_f,
    input  logic op_h,
    input  logic op_m,
    input  logic op_n,
    input  logic op_phi,
    input  logic op_theta,
    input  logic digit_pulse,
    output logic busy,
    output logic done,
    output logic err,
    output logic f13_pos,
    output logic f13_neg,
    output logic f14_pos,
    output logic f14_neg,
    output logic f15_pos,
    output logic f15_neg,
    output logic ser_pos,
    output logic ser_neg
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state;
    logic [1:0]  count;
    logic [2:0]  f_pos;
    logic [2:0]  f_neg;
    logic [7:0]  ops;
    logic [2:0]  enc;
    logic        one_hot;
    logic        cur_digit;

    assign ops = {op_theta, op_phi, op_n, op_m, op_h, op_f, op_d, op_blank};

    always_comb begin
        enc = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (ops[i]) enc = 3'(i);
        end
        one_hot = (ops != 8'd0) && ((ops & (ops - 8'd1)) == 8'd0);
    end

    // f_pos holds the latched code once captured; f_neg is its complement
    always_comb begin
        cur_digit = 1'b0;
        unique case (count)
            2'd0:    cur_digit = f_pos[0];
            2'd1:    cur_digit = f_pos[1];
            2'd2:    cur_digit = f_pos[2];
            default: cur_digit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= 2'd0;
            f_pos   <= 3'd0;
            f_neg   <= 3'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            ser_pos <= 1'b0;
            ser_neg <= 1'b0;
        end else begin
            done    <= 1'b0;
            err     <= 1'b0;
            ser_pos <= 1'b0;
            ser_neg <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load) begin
                        if (one_hot) begin
                            f_pos <= enc;
                            f_neg <= ~enc;
                            count <= 2'd0;
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (digit_pulse) begin
                        ser_pos <= cur_digit;
                        ser_neg <= ~cur_digit;
                        if (count == 2'd2) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            count <= count + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign f13_pos = f_pos[0];
    assign f13_neg = f_neg[0];
    assign f14_pos = f_pos[1];
    assign f14_neg = f_neg[1];
    assign f15_pos = f_pos[2];
    assign f15_neg = f_neg[2];

endmodule

// File: tb/tb_order_encoder2_2.sv
// Randomised and directed bench for order_encoder2_2 against a
// queue-based model of the pending serial digits.
module tb_order_encoder2_2;

    logic clk = 1'b0;
    logic rst, load, digit_pulse;
    logic [7:0] ops;
    logic busy, done, err, ser_pos, ser_neg;
    logic f13_pos, f13_neg, f14_pos, f14_neg, f15_pos, f15_neg;

    int errors = 0;
    int checks = 0;

    // model state
    logic       m_busy = 1'b0;
    logic       m_valid = 1'b0;
    logic [2:0] m_code = 3'd0;
    logic       e_done, e_err, e_sp, e_sn;
    int         q[$];

    always #5 clk = ~clk;

    order_encoder2_2 dut (
        .clk(clk), .rst(rst), .load(load),
        .op_blank(ops[0]), .op_d(ops[1]), .op_f(ops[2]), .op_h(ops[3]),
        .op_m(ops[4]), .op_n(ops[5]), .op_phi(ops[6]), .op_theta(ops[7]),
        .digit_pulse(digit_pulse),
        .busy(busy), .done(done), .err(err),
        .f13_pos(f13_pos), .f13_neg(f13_neg),
        .f14_pos(f14_pos), .f14_neg(f14_neg),
        .f15_pos(f15_pos), .f15_neg(f15_neg),
        .ser_pos(ser_pos), .ser_neg(ser_neg)
    );

    function automatic logic [10:0] obs();
        return {busy, done, err, ser_pos, ser_neg,
                f13_pos, f13_neg, f14_pos, f14_neg, f15_pos, f15_neg};
    endfunction

    function automatic logic [10:0] expv();
        logic [5:0] par;
        par = 6'd0;
        if (m_valid)
            par = {m_code[0], !m_code[0], m_code[1], !m_code[1],
                   m_code[2], !m_code[2]};
        return {m_busy, e_done, e_err, e_sp, e_sn, par};
    endfunction

    // apply one cycle of inputs, advance the model, land 1 time unit after the edge
    task automatic tick(input logic r, input logic ld,
                        input logic [7:0] op, input logic dp);
        int n, idx, d;
        rst = r; load = ld; ops = op; digit_pulse = dp;
        e_done = 0; e_err = 0; e_sp = 0; e_sn = 0;
        if (r) begin
            m_busy = 0; m_valid = 0; m_code = 0; q.delete();
        end else if (!m_busy) begin
            if (ld) begin
                n = 0; idx = 0;
                for (int i = 0; i < 8; i++)
                    if (op[i]) begin n++; idx = i; end
                if (n == 1) begin
                    m_code = 3'(idx); m_valid = 1; m_busy = 1;
                    q = {idx % 2, (idx / 2) % 2, idx / 4};
                end else e_err = 1;
            end
        end else if (dp) begin
            d = q.pop_front();
            e_sp = (d == 1); e_sn = (d == 0);
            if (q.size() == 0) begin e_done = 1; m_busy = 0; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [10:0] o;
        tick(1, 1, 8'h80, 0);
        tick(1, 1, 8'h80, 0);
        o = obs();
        checks++;
        if (o !== 11'd0) begin
            errors++;
            $display("FAIL reset obs=%b req=%b", o, 11'd0);
        end
        tick(0, 0, 0, 0);
        o = obs();
        checks++;
        if (o !== expv()) begin
            errors++;
            $display("FAIL reset_hold obs=%b req=%b", o, expv());
        end
    endtask

    task automatic test_encode_sweep();
        logic [10:0] o;
        logic [2:0] sp;
        for (int k = 0; k < 8; k++) begin
            tick(0, 1, 8'(1 << k), 1);
            o = obs();
            checks++;
            if (o !== expv()) begin
                errors++;
                $display("FAIL sweep_cap op=%0d obs=%b req=%b", k, o, expv());
            end
            for (int p = 0; p < 3; p++) begin
                tick(0, 0, 0, 1);
                sp[p] = ser_pos;
                o = obs();
                checks++;
                if (o !== expv()) begin
                    errors++;
                    $display("FAIL sweep_ser op=%0d dig=%0d obs=%b req=%b",
                             k, p, o, expv());
                end
            end
            checks++;
            if (sp !== 3'(k)) begin
                errors++;
                $display("FAIL sweep_seq op=%0d got=%b req=%b", k, sp, 3'(k));
            end
        end
    endtask

    task automatic test_sparse();
        logic [10:0] o;
        tick(0, 1, 8'h10, 0);
        for (int c = 1; c <= 10; c++) begin
            tick(0, 0, 0, (c == 3 || c == 7 || c == 8));
            o = obs();
            checks++;
            if (o !== expv()) begin
                errors++;
                $display("FAIL sparse c=%0d obs=%b req=%b", c, o, expv());
            end
        end
    endtask

    task automatic test_invalid();
        logic [10:0] o;
        tick(0, 1, 8'h06, 0);
        o = obs();
        checks++;
        if (o !== expv() || err !== 1'b1) begin
            errors++;
            $display("FAIL inv_two obs=%b req=%b", o, expv());
        end
        tick(0, 1, 8'h00, 0);
        o = obs();
        checks++;
        if (o !== expv() || err !== 1'b1) begin
            errors++;
            $display("FAIL inv_zero obs=%b req=%b", o, expv());
        end
        tick(0, 1, 8'h08, 0);
        for (int c = 0; c < 5; c++) begin
            tick(0, 1, 8'h40, c[0]);
            o = obs();
            checks++;
            if (o !== expv()) begin
                errors++;
                $display("FAIL inv_shift c=%0d obs=%b req=%b", c, o, expv());
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] o;
        tick(0, 0, 0, 0);
        tick(0, 1, 8'h20, 0);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        for (int c = 0; c < 5; c++) begin
            tick(0, c == 0, 8'h40, c > 0);
            o = obs();
            checks++;
            if (o !== expv()) begin
                errors++;
                $display("FAIL b2b c=%0d obs=%b req=%b", c, o, expv());
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] o;
        tick(0, 1, 8'h08, 0);
        tick(0, 0, 0, 1);
        tick(1, 0, 0, 1);
        o = obs();
        checks++;
        if (o !== 11'd0) begin
            errors++;
            $display("FAIL rst_mid obs=%b req=%b", o, 11'd0);
        end
        tick(0, 1, 8'h04, 0);
        for (int c = 0; c < 4; c++) begin
            tick(0, 0, 0, 1);
            o = obs();
            checks++;
            if (o !== expv()) begin
                errors++;
                $display("FAIL rst_after c=%0d obs=%b req=%b", c, o, expv());
            end
        end
    endtask

    task automatic test_random();
        logic [10:0] o;
        logic [7:0] op;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(3) != 0) op = 8'(1 << $urandom_range(7));
            else op = 8'($urandom);
            tick($urandom_range(40) == 0, $urandom_range(2) == 0, op,
                 $urandom_range(1) == 1);
            o = obs();
            checks++;
            if (o !== expv()) begin
                errors++;
                $display("FAIL random c=%0d obs=%b req=%b", c, o, expv());
            end
        end
    endtask

    initial begin
        rst = 1; load = 0; ops = 0; digit_pulse = 0;
        #2;
        test_reset();
        test_encode_sweep();
        test_sparse();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
